mips32_mem_arbiter: RTL

Single-ported memory arbiter and sequencer for the mips32 core. Shares one unified instruction/data memory between three requesters: the instruction-fetch stage, the data (LW/SW) stage, and a program loader that is only served while the core is halted. Sits between the pipeline's memory-access points and the memory array, and replaces direct hierarchical access to the memory with a handshaked port.

---
 rtl/mips32_arb_pkg.sv | 29 ++
 rtl/mips32_mem_arbiter_if.sv | 64 ++++++
 rtl/mips32_arb_pick.sv | 32 +++
 rtl/mips32_mem_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mips32_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips32_arb_pkg
// Description : Shared types and constants for the mips32 memory arbiter:
//               sequencer states, grant-owner encoding, starvation limit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips32_arb_pkg;

    // Sequencer states: pick in IDLE, strobe memory in ISSUE, count read
    // latency in WAIT, acknowledge the owner in DONE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Owner encoding reported on gnt_id.
    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_IF   = 2'd1;
    localparam logic [1:0] GNT_D    = 2'd2;
    localparam logic [1:0] GNT_LD   = 2'd3;

    // Number of consecutive D-over-IF wins after which IF is forced through.
    localparam logic [1:0] STARVE_LIMIT = 2'd3;

endpackage : mips32_arb_pkg
`default_nettype wire

// File: rtl/mips32_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mips32_mem_arbiter_if
// Description : Requester and memory-side bundle of the mips32 memory
//               arbiter. slave = arbiter view, master = environment view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips32_mem_arbiter_if #(
    parameter int AW = 10
) ();
    logic          halted;

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [31:0]   if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_ack;
    logic [31:0]   d_rdata;

    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_wdata;
    logic          ld_ack;
    logic [31:0]   ld_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic          busy;
    logic [1:0]    gnt_id;

    modport slave (
        input  halted,
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        input  mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, ld_ack, ld_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, gnt_id
    );

    modport master (
        output halted,
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output ld_req, ld_we, ld_addr, ld_wdata,
        output mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, ld_ack, ld_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, gnt_id
    );

endinterface : mips32_mem_arbiter_if
`default_nettype wire

// File: rtl/mips32_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mips32_arb_pick
// Description : Combinational winner selection. LD (only while halted) beats
//               D, D beats IF unless IF has been skipped STARVE_LIMIT times.
// Revision    : 1.0 - initial release
// ============================================================================
module mips32_arb_pick
    import mips32_arb_pkg::*;
(
    input  wire logic       if_req,
    input  wire logic       d_req,
    input  wire logic       ld_req,
    input  wire logic       halted,
    input  wire logic [1:0] skip_cnt,
    output logic      [1:0] winner
);

    // Fixed priority with a starvation override that only demotes D.
    always_comb begin
        winner = GNT_NONE;
        if (ld_req && halted) begin
            winner = GNT_LD;
        end else if (d_req && !(if_req && (skip_cnt == STARVE_LIMIT))) begin
            winner = GNT_D;
        end else if (if_req) begin
            winner = GNT_IF;
        end
    end

endmodule : mips32_arb_pick
`default_nettype wire

// File: rtl/mips32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mips32_mem_arbiter
// Description : Single-port memory arbiter/sequencer shared by instruction
//               fetch, data access and the program loader. One transaction
//               at a time: IDLE -> ISSUE -> [WAIT x MEM_LAT] -> DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module mips32_mem_arbiter
    import mips32_arb_pkg::*;
#(
    parameter int AW      = 10,
    parameter int MEM_LAT = 1
) (
    input  wire logic           clk1,
    input  wire logic           rst,
    mips32_mem_arbiter_if.slave bus
);

    // WAIT counts MEM_LAT cycles down to zero; the last one captures data.
    localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT - 1);

    state_t        state_q,  state_d;
    logic [1:0]    gnt_id_q, gnt_id_d;
    logic          we_q,     we_d;
    logic [AW-1:0] addr_q,   addr_d;
    logic [31:0]   wdata_q,  wdata_d;
    logic [31:0]   rdata_q,  rdata_d;
    logic [1:0]    skip_q,   skip_d;
    logic [2:0]    wait_q,   wait_d;
    logic [1:0]    winner;

    mips32_arb_pick u_pick (
        .if_req   (bus.if_req),
        .d_req    (bus.d_req),
        .ld_req   (bus.ld_req),
        .halted   (bus.halted),
        .skip_cnt (skip_q),
        .winner   (winner)
    );

    // Next-state, grant latch, skip counter and read-data capture.
    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        skip_d   = skip_q;
        wait_d   = wait_q;
        case (state_q)
            IDLE: begin
                if (winner != GNT_NONE) begin
                    state_d  = ISSUE;
                    gnt_id_d = winner;
                end
                case (winner)
                    GNT_LD: begin
                        we_d    = bus.ld_we;
                        addr_d  = bus.ld_addr;
                        wdata_d = bus.ld_wdata;
                    end
                    GNT_D: begin
                        we_d    = bus.d_we;
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                        // IF lost to D while asking: one step closer to override.
                        if (bus.if_req) begin
                            skip_d = skip_q + 2'd1;
                        end
                    end
                    GNT_IF: begin
                        we_d    = 1'b0;
                        addr_d  = bus.if_addr;
                        wdata_d = '0;
                        skip_d  = '0;
                    end
                    default: ;
                endcase
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                    wait_d  = WAIT_INIT;
                end
            end
            WAIT: begin
                if (wait_q == 3'd0) begin
                    rdata_d = bus.mem_rdata;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            DONE: begin
                state_d  = IDLE;
                gnt_id_d = GNT_NONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_id_q <= GNT_NONE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            skip_q   <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            skip_q   <= skip_d;
            wait_q   <= wait_d;
        end
    end

    // Memory strobe is live only in ISSUE; everything else is held at zero.
    assign bus.mem_en    = (state_q == ISSUE);
    assign bus.mem_we    = (state_q == ISSUE) && we_q;
    assign bus.mem_addr  = (state_q == ISSUE) ? addr_q  : '0;
    assign bus.mem_wdata = (state_q == ISSUE) ? wdata_q : '0;

    assign bus.if_ack   = (state_q == DONE) && (gnt_id_q == GNT_IF);
    assign bus.d_ack    = (state_q == DONE) && (gnt_id_q == GNT_D);
    assign bus.ld_ack   = (state_q == DONE) && (gnt_id_q == GNT_LD);
    assign bus.if_rdata = rdata_q;
    assign bus.d_rdata  = rdata_q;
    assign bus.ld_rdata = rdata_q;

    assign bus.busy   = (state_q != IDLE);
    assign bus.gnt_id = gnt_id_q;

endmodule : mips32_mem_arbiter
`default_nettype wire
